// File: rtl/infeasi_res_s2_hls_deadlock_pkg.sv
// Shared types and width helpers for the HLS deadlock report controller.
// Modules size their counters and index ports from their own parameters.
package infeasi_res_s2_hls_deadlock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_ORIGIN,
        ST_TRACE,
        ST_REPORT,
        ST_HOLD
    } state_t;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of an index into n entries. It is never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/infeasi_res_s2_hls_dl_prio_enc.sv
// Lowest-set-bit priority encoder. It produces a one-hot vector and a binary index.
// The logic is purely combinational. An all-zero input gives all-zero outputs.
module infeasi_res_s2_hls_dl_prio_enc
    import infeasi_res_s2_hls_deadlock_pkg::*;
#(
    parameter  int PROC_NUM = 4,
    localparam int IDX_W    = idx_width(PROC_NUM)
) (
    input  logic [PROC_NUM-1:0] vec,
    output logic [PROC_NUM-1:0] onehot,
    output logic [IDX_W-1:0]    idx
);

    // NOTE: every output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        // The scan runs from the top down, so the lowest set bit is written last and wins.
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/infeasi_res_s2_hls_deadlock_report_ctrl.sv
// Controller for deadlock confirmation, origin selection, token trace and reporting.
// Every output is registered. A deadlock is reported once, and only reset clears it.
module infeasi_res_s2_hls_deadlock_report_ctrl
    import infeasi_res_s2_hls_deadlock_pkg::*;
#(
    parameter  int PROC_NUM       = 4,
    parameter  int CONFIRM_CYCLES = 2,
    parameter  int TRACE_TIMEOUT  = 64,
    localparam int ORIGIN_W       = idx_width(PROC_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] dl_token_vec,
    output logic                dl_detect_global,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                report_vld,
    input  logic                report_ack,
    output logic [PROC_NUM-1:0] report_proc_vec,
    output logic [ORIGIN_W-1:0] report_origin,
    output logic                report_timeout,
    output logic                deadlock_flag
);

    localparam int CONF_W  = cnt_width(CONFIRM_CYCLES);
    localparam int TRACE_W = cnt_width(TRACE_TIMEOUT);

    state_t              state, state_nxt;
    logic [CONF_W-1:0]   conf_cnt, conf_cnt_nxt, conf_next;
    logic [TRACE_W-1:0]  trace_cnt, trace_cnt_nxt, trace_inc;
    logic [PROC_NUM-1:0] det_onehot;
    logic [ORIGIN_W-1:0] det_idx;
    logic                token_back;

    logic                dl_detect_global_nxt, token_clear_nxt, report_vld_nxt;
    logic                report_timeout_nxt, deadlock_flag_nxt;
    logic [PROC_NUM-1:0] origin_vec_nxt, report_proc_vec_nxt;
    logic [ORIGIN_W-1:0] report_origin_nxt;

    infeasi_res_s2_hls_dl_prio_enc #(.PROC_NUM(PROC_NUM)) u_prio_enc (
        .vec    (dl_detect_vec),
        .onehot (det_onehot),
        .idx    (det_idx)
    );

    always_comb begin
        state_nxt            = state;
        conf_cnt_nxt         = conf_cnt;
        trace_cnt_nxt        = trace_cnt;
        dl_detect_global_nxt = dl_detect_global;
        origin_vec_nxt       = '0;
        token_clear_nxt      = 1'b0;
        report_vld_nxt       = report_vld;
        report_proc_vec_nxt  = report_proc_vec;
        report_origin_nxt    = report_origin;
        report_timeout_nxt   = report_timeout;
        deadlock_flag_nxt    = deadlock_flag;
        conf_next            = conf_cnt + 1'b1;
        trace_inc            = (trace_cnt == TRACE_W'(TRACE_TIMEOUT)) ? trace_cnt : trace_cnt + 1'b1;
        // report_origin holds the latched origin index from confirmation onward.
        token_back           = dl_token_vec[report_origin] & dl_detect_vec[report_origin];

        case (state)
            ST_IDLE, ST_CONFIRM: begin
                if (!(|dl_detect_vec)) begin
                    state_nxt    = ST_IDLE;
                    conf_cnt_nxt = '0;
                end else if (conf_next == CONF_W'(CONFIRM_CYCLES)) begin
                    state_nxt            = ST_ORIGIN;
                    conf_cnt_nxt         = '0;
                    origin_vec_nxt       = det_onehot;
                    report_proc_vec_nxt  = det_onehot;
                    report_origin_nxt    = det_idx;
                    dl_detect_global_nxt = 1'b1;
                    trace_cnt_nxt        = '0;
                end else begin
                    state_nxt    = ST_CONFIRM;
                    conf_cnt_nxt = conf_next;
                end
            end
            ST_ORIGIN: begin
                state_nxt     = ST_TRACE;
                trace_cnt_nxt = '0;
            end
            ST_TRACE: begin
                report_proc_vec_nxt = report_proc_vec | dl_token_vec;
                trace_cnt_nxt       = trace_inc;
                // If the token returns in the same cycle the trace times out, the return takes priority.
                if (token_back || trace_inc == TRACE_W'(TRACE_TIMEOUT)) begin
                    state_nxt          = ST_REPORT;
                    token_clear_nxt    = 1'b1;
                    report_timeout_nxt = !token_back;
                    report_vld_nxt     = 1'b1;
                    deadlock_flag_nxt  = 1'b1;
                end
            end
            ST_REPORT: begin
                if (report_ack) begin
                    state_nxt      = ST_HOLD;
                    report_vld_nxt = 1'b0;
                end
            end
            ST_HOLD: ;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Reset clears every register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= ST_IDLE;
            conf_cnt         <= '0;
            trace_cnt        <= '0;
            dl_detect_global <= 1'b0;
            origin_vec       <= '0;
            token_clear      <= 1'b0;
            report_vld       <= 1'b0;
            report_proc_vec  <= '0;
            report_origin    <= '0;
            report_timeout   <= 1'b0;
            deadlock_flag    <= 1'b0;
        end else begin
            state            <= state_nxt;
            conf_cnt         <= conf_cnt_nxt;
            trace_cnt        <= trace_cnt_nxt;
            dl_detect_global <= dl_detect_global_nxt;
            origin_vec       <= origin_vec_nxt;
            token_clear      <= token_clear_nxt;
            report_vld       <= report_vld_nxt;
            report_proc_vec  <= report_proc_vec_nxt;
            report_origin    <= report_origin_nxt;
            report_timeout   <= report_timeout_nxt;
            deadlock_flag    <= deadlock_flag_nxt;
        end
    end

endmodule

// File: tb/tb_infeasi_res_s2_hls_deadlock_report_ctrl.sv
// Self-checking bench for the deadlock report controller (PROC_NUM=4, CONFIRM=2, TIMEOUT=8).
// The bench runs directed scenarios and then random episodes against a behavioural episode model.
module tb_infeasi_res_s2_hls_deadlock_report_ctrl;

    localparam int PN = 4;
    localparam int CC = 2;
    localparam int TT = 8;
    localparam int OW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [PN-1:0] dl_detect_vec, dl_token_vec;
    logic          report_ack;
    logic          dl_detect_global, token_clear, report_vld, report_timeout, deadlock_flag;
    logic [PN-1:0] origin_vec, report_proc_vec;
    logic [OW-1:0] report_origin;

    int total = 0;
    int bad   = 0;

    // Model: episode progress (0 search, 1 origin, 2 trace, 3 report, 4 done) and expected outputs.
    int            m_stage, m_streak, m_tcnt, m_origin;
    logic [PN-1:0] e_ov, e_pv;
    logic [OW-1:0] e_ro;
    logic          e_glob, e_tc, e_vld, e_to, e_flag;

    infeasi_res_s2_hls_deadlock_report_ctrl #(
        .PROC_NUM(PN), .CONFIRM_CYCLES(CC), .TRACE_TIMEOUT(TT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .dl_detect_vec    (dl_detect_vec),
        .dl_token_vec     (dl_token_vec),
        .dl_detect_global (dl_detect_global),
        .origin_vec       (origin_vec),
        .token_clear      (token_clear),
        .report_vld       (report_vld),
        .report_ack       (report_ack),
        .report_proc_vec  (report_proc_vec),
        .report_origin    (report_origin),
        .report_timeout   (report_timeout),
        .deadlock_flag    (deadlock_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [PN-1:0] v);
        int r = 0;
        for (int i = PN - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_step();
        bit ret;
        if (!reset) begin
            m_stage = 0; m_streak = 0; m_tcnt = 0; m_origin = 0;
            e_ov = '0; e_pv = '0; e_ro = '0;
            e_glob = 0; e_tc = 0; e_vld = 0; e_to = 0; e_flag = 0;
        end else begin
            e_ov = '0;
            e_tc = 0;
            case (m_stage)
                0: begin
                    if (dl_detect_vec != '0) begin
                        m_streak++;
                        if (m_streak >= CC) begin
                            m_origin = lowest(dl_detect_vec);
                            m_stage  = 1;
                            m_streak = 0;
                            m_tcnt   = 0;
                            e_ov     = PN'(1) << m_origin;
                            e_pv     = e_ov;
                            e_ro     = OW'(m_origin);
                            e_glob   = 1;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
                1: m_stage = 2;
                2: begin
                    e_pv   = e_pv | dl_token_vec;
                    m_tcnt = (m_tcnt + 1 > TT) ? TT : m_tcnt + 1;
                    ret    = dl_token_vec[m_origin] && dl_detect_vec[m_origin];
                    if (ret || m_tcnt == TT) begin
                        e_tc    = 1;
                        e_to    = !ret;
                        e_vld   = 1;
                        e_flag  = 1;
                        m_stage = 3;
                    end
                end
                3: if (report_ack) begin
                    e_vld   = 0;
                    m_stage = 4;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        check("origin_vec", 32'(origin_vec), 32'(e_ov));
        check("dl_detect_global", 32'(dl_detect_global), 32'(e_glob));
        check("token_clear", 32'(token_clear), 32'(e_tc));
        check("report_vld", 32'(report_vld), 32'(e_vld));
        check("report_proc_vec", 32'(report_proc_vec), 32'(e_pv));
        check("report_origin", 32'(report_origin), 32'(e_ro));
        check("report_timeout", 32'(report_timeout), 32'(e_to));
        check("deadlock_flag", 32'(deadlock_flag), 32'(e_flag));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, and check outputs 1 time unit later.
    task automatic cyc(input logic [PN-1:0] det, input logic [PN-1:0] tok, input logic ack, input logic rst_n);
        reset         = rst_n;
        dl_detect_vec = det;
        dl_token_vec  = tok;
        report_ack    = ack;
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        // Reset with random inputs, which the design must ignore.
        cyc(PN'($urandom), PN'($urandom), 1'b1, 1'b0);
        cyc(PN'($urandom), PN'($urandom), 1'b1, 1'b0);
        check("reset_flag", 32'(deadlock_flag), 32'd0);

        // A single-cycle detect pulse must drop back without producing an origin.
        cyc(4'b0010, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("glitch_no_global", 32'(dl_detect_global), 32'd0);

        // Two cycles of detect confirm origin 2.
        cyc(4'b0100, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b1);
        check("origin2_pulse", 32'(origin_vec), 32'h4);
        check("origin2_index", 32'(report_origin), 32'd2);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("origin2_pulse_end", 32'(origin_vec), 32'd0);
        check("origin2_global", 32'(dl_detect_global), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Origin 1: the token walks 0100, 1000, then returns. A stray ack during trace is ignored.
        cyc(4'b0010, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0010, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
        cyc(4'b0000, 4'b0100, 1'b1, 1'b1);
        cyc(4'b0000, 4'b1000, 1'b0, 1'b1);
        cyc(4'b0010, 4'b0010, 1'b0, 1'b1);
        check("return_clear", 32'(token_clear), 32'd1);
        check("return_procs", 32'(report_proc_vec), 32'he);
        check("return_no_timeout", 32'(report_timeout), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
        check("first_cycle_ack", 32'(report_vld), 32'd0);
        for (int i = 0; i < 3; i++) cyc(PN'($urandom), PN'($urandom), 1'($urandom), 1'b1);
        check("hold_flag", 32'(deadlock_flag), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Origin 0 never returns: timeout after 8 trace cycles, then ack arrives in the fifth report cycle.
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < TT; i++) cyc(PN'($urandom), PN'($urandom) & 4'b1110, 1'($urandom), 1'b1);
        check("timeout_clear", 32'(token_clear), 32'd1);
        check("timeout_flag", 32'(report_timeout), 32'd1);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("vld_held", 32'(report_vld), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
        check("vld_dropped", 32'(report_vld), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset while the report is pending clears everything.
        cyc(4'b1000, 4'b0000, 1'b0, 1'b1);
        cyc(4'b1000, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc(4'b1000, 4'b1000, 1'b0, 1'b1);
        check("pre_reset_vld", 32'(report_vld), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("reset_mid_report_flag", 32'(deadlock_flag), 32'd0);

        // For detect 1010 the lowest set bit gives origin 1. Return and timeout then coincide.
        cyc(4'b1010, 4'b0000, 1'b0, 1'b1);
        cyc(4'b1010, 4'b0000, 1'b0, 1'b1);
        check("lsb_origin", 32'(report_origin), 32'd1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < TT - 1; i++) cyc(4'b0000, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0010, 4'b0010, 1'b0, 1'b1);
        check("tie_return_wins", 32'(report_timeout), 32'd0);
        check("tie_clear", 32'(token_clear), 32'd1);

        // Random episodes.
        for (int ep = 0; ep < 20; ep++) begin
            cyc(4'b0000, 4'b0000, 1'b0, 1'b0);
            for (int c = 0; c < 40; c++) begin
                cyc(($urandom_range(0, 3) == 0) ? 4'b0000 : PN'($urandom),
                    PN'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/infeasi_res_s2_hls_deadlock_report_ctrl.md
INFEASI_RES_S2_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: infeasi_res_s2_hls_deadlock_report_ctrl

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of monitored processes.
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 2: consecutive cycles of nonzero detect before trace starts (>=1).
REQ-003 SHALL have parameter TRACE_TIMEOUT, default 64: max TRACE cycles before forced report.
REQ-004 SHALL have port clock, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port dl_detect_vec, input, PROC_NUM: per-process dl_detect_out from the detect units.
REQ-007 SHALL have port dl_token_vec, input, PROC_NUM: per-process token-held indication (OR of each unit's token_in_vec).
REQ-008 SHALL have port dl_detect_global, output, 1: broadcast dl_detect_in to all detect units.
REQ-009 SHALL have port origin_vec, output, PROC_NUM: one-hot origin pulse to the selected unit.
REQ-010 SHALL have port token_clear, output, 1: one-cycle token kill broadcast.
REQ-011 SHALL have ports report_vld (out, 1), report_ack (in, 1), report_proc_vec (out, PROC_NUM), report_origin (out, $clog2(PROC_NUM)), report_timeout (out, 1): deadlock report handshake.
REQ-012 SHALL have port deadlock_flag, output, 1: sticky deadlock indication.

Function
REQ-013 SHALL implement states IDLE, CONFIRM, ORIGIN, TRACE, REPORT, HOLD; all outputs registered.
REQ-014 IDLE: |dl_detect_vec -> CONFIRM with confirm count 1; if CONFIRM_CYCLES==1 go directly to ORIGIN.
REQ-015 CONFIRM: count increments while |dl_detect_vec; vector all-zero in any cycle -> IDLE, count cleared; count reaching CONFIRM_CYCLES -> ORIGIN.
REQ-016 Origin index SHALL be the lowest set bit of dl_detect_vec in the cycle confirmation completes; latched until reset.
REQ-017 ORIGIN: origin_vec = one-hot(origin) for exactly one cycle; dl_detect_global = 1 from this cycle until reset; report_proc_vec initialised to one-hot(origin); trace counter cleared; next state TRACE.
REQ-018 TRACE: each cycle report_proc_vec |= dl_token_vec; trace counter increments, saturating at TRACE_TIMEOUT.
REQ-019 TRACE: dl_token_vec[origin] & dl_detect_vec[origin] (token returned) -> token_clear = 1 for one cycle, report_timeout = 0, -> REPORT.
REQ-020 TRACE: counter reaching TRACE_TIMEOUT without return -> token_clear pulse, report_timeout = 1, -> REPORT.
REQ-021 Return and timeout in the same cycle: return wins, report_timeout = 0.
REQ-022 REPORT: report_vld = 1 and report_* stable until report_ack sampled high; ack in the cycle report_vld first rises is accepted; then -> HOLD next cycle.
REQ-023 report_ack outside REPORT SHALL be ignored.
REQ-024 deadlock_flag SHALL rise on entry to REPORT and stay high through HOLD.
REQ-025 HOLD: terminal; dl_detect_global = 1, report_vld = 0, report fields retained; exit only by reset.
REQ-026 origin_vec and token_clear SHALL be zero in every state except their single pulse cycles.

Reset
REQ-027 reset low at a rising edge SHALL force state IDLE and all outputs and internal counters/registers to 0 in the next cycle, from any state including mid-TRACE/REPORT.
REQ-028 Inputs SHALL be ignored during reset; first detection evaluated the cycle after reset deasserts.

Structure
REQ-029 State enum, state width, and counter-width derivations ($clog2(TRACE_TIMEOUT+1), $clog2(PROC_NUM)) SHALL live in shared package infeasi_res_s2_hls_deadlock_pkg.
REQ-030 Lowest-set-bit selection SHALL be one sub-module infeasi_res_s2_hls_dl_prio_enc (PROC_NUM in, one-hot and index out, combinational).
REQ-031 Target size 120-400 RTL lines; no other sub-modules.

Verification (PROC_NUM=4, CONFIRM_CYCLES=2, TRACE_TIMEOUT=8)
REQ-032 dl_detect_vec=4'b0100 for 2 cycles -> origin_vec=4'b0100 one cycle, dl_detect_global=1 thereafter, report_origin=2.
REQ-033 dl_detect_vec=4'b0010 one cycle then 0 -> return to IDLE, no origin pulse, dl_detect_global stays 0.
REQ-034 origin 1; dl_token_vec walks 4'b0100, 4'b1000, then 4'b0010 with dl_detect_vec[1]=1 -> token_clear one cycle, report_proc_vec=4'b1110, report_timeout=0.
REQ-035 origin 0, token never returns -> after 8 TRACE cycles token_clear pulse, report_vld=1, report_timeout=1; report_vld held 5 cycles until report_ack, then 0, deadlock_flag=1.
REQ-036 dl_detect_vec=4'b1010 confirmed -> origin index 1 (lowest set bit).
REQ-037 reset low during REPORT with report_vld=1 -> next cycle all outputs 0, state IDLE, deadlock_flag=0.
